altddio_out: RTL and testbench

ALTDDIO_OUT -- requirements
Module: altddio_out

---
 rtl/altddio_out_pkg.sv | 14 +
 rtl/altddio_out_cell.sv | 68 ++++++
 rtl/altddio_out.sv | 77 +++++++
 tb/tb_altddio_out.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/altddio_out_pkg.sv
// Shared parameter string constants and decode helper for the altddio_out DDR output block.
package altddio_out_pkg;

   localparam string P_ON           = "ON";
   localparam string P_OFF          = "OFF";
   localparam string P_REGISTERED   = "REGISTERED";
   localparam string P_UNREGISTERED = "UNREGISTERED";

   // Any value other than the exact match decodes as the parameter's default.
   function automatic bit param_is(input string val, input string match);
      return (val == match);
   endfunction

endpackage

// File: rtl/altddio_out_cell.sv
// One DDR output bit: rise/fall capture registers, phase mux and optional inversion.
// Synchronous clear/set exists only when ALTDDIO_OUT_SYNC_CTRL_EN is defined.
module ddio_out_cell
   import altddio_out_pkg::*;
#(
   parameter bit INVERT = 1'b0,
   parameter bit INIT   = 1'b0
) (
   input  logic outclock,
   input  logic aclr_n,
   input  logic ena,
   input  logic sclr,
   input  logic sset,
   input  logic d_h,
   input  logic d_l,
   output logic q
);

   logic reg_h_q, reg_h_d;
   logic reg_l_pre_q, reg_l_pre_d;
   logic reg_l_q;

   always_comb begin
      reg_h_d     = reg_h_q;
      reg_l_pre_d = reg_l_pre_q;
      if (ena) begin
`ifdef ALTDDIO_OUT_SYNC_CTRL_EN
         if (sclr) begin
            reg_h_d     = 1'b0;
            reg_l_pre_d = 1'b0;
         end else if (sset) begin
            reg_h_d     = 1'b1;
            reg_l_pre_d = 1'b1;
         end else begin
            reg_h_d     = d_h;
            reg_l_pre_d = d_l;
         end
`else
         reg_h_d     = d_h;
         reg_l_pre_d = d_l;
`endif
      end
   end

`ifndef ALTDDIO_OUT_SYNC_CTRL_EN
   logic unused_ctrl;
   assign unused_ctrl = sclr ^ sset;
`endif

   always_ff @(posedge outclock or negedge aclr_n) begin
      if (!aclr_n) begin
         reg_h_q     <= INIT;
         reg_l_pre_q <= INIT;
      end else begin
         reg_h_q     <= reg_h_d;
         reg_l_pre_q <= reg_l_pre_d;
      end
   end

   // Low-phase data is re-timed to the falling edge so it cannot glitch into the high phase.
   always_ff @(negedge outclock or negedge aclr_n) begin
      if (!aclr_n) reg_l_q <= INIT;
      else         reg_l_q <= reg_l_pre_q;
   end

   assign q = (outclock ? reg_h_q : reg_l_q) ^ INVERT;

endmodule

// File: rtl/altddio_out.sv
// DDR output register with shared output-enable logic and tri-state output.
// Define ALTDDIO_OUT_SYNC_CTRL_EN to enable the synchronous sclr/sset controls.
module altddio_out
   import altddio_out_pkg::*;
#(
   parameter int    WIDTH                  = 1,
   parameter string INVERT_OUTPUT          = "OFF",
   parameter string OE_REG                 = "UNREGISTERED",
   parameter string EXTEND_OE_DISABLE      = "OFF",
   parameter string POWER_UP_HIGH          = "OFF",
   parameter string INTENDED_DEVICE_FAMILY = "Cyclone V",
   parameter string LPM_HINT               = "UNUSED",
   parameter string LPM_TYPE               = "altddio_out"
) (
   input  logic             outclock,
   input  logic             aclr_n,
   input  logic [WIDTH-1:0] datain_h,
   input  logic [WIDTH-1:0] datain_l,
   input  logic             outclocken,
   input  logic             oe,
   input  logic             sclr,
   input  logic             sset,
   output wire  [WIDTH-1:0] dataout
);

   localparam bit INV_EN  = param_is(INVERT_OUTPUT, P_ON);
   localparam bit OE_REGD = param_is(OE_REG, P_REGISTERED);
   localparam bit OE_EXT  = OE_REGD && param_is(EXTEND_OE_DISABLE, P_ON);
   localparam bit INIT_HI = param_is(POWER_UP_HIGH, P_ON);

   logic unused_attr;
   assign unused_attr = param_is(INTENDED_DEVICE_FAMILY, "") ^ param_is(LPM_HINT, "")
                        ^ param_is(LPM_TYPE, "") ^ param_is(OE_REG, P_UNREGISTERED)
                        ^ param_is(EXTEND_OE_DISABLE, P_OFF);

   logic oe_r_q, oe_r_d;
   logic oe_f_q;
   logic oe_eff;
   logic [WIDTH-1:0] drv;

   assign oe_r_d = outclocken ? oe : oe_r_q;

   always_ff @(posedge outclock or negedge aclr_n) begin
      if (!aclr_n) oe_r_q <= 1'b0;
      else         oe_r_q <= oe_r_d;
   end

   always_ff @(negedge outclock or negedge aclr_n) begin
      if (!aclr_n) oe_f_q <= 1'b0;
      else         oe_f_q <= oe_r_q;
   end

   // Extended mode: disable follows oe_r at once, re-enable waits for the falling-edge copy.
   always_comb begin
      oe_eff = oe;
      if (OE_REGD) oe_eff = OE_EXT ? (oe_r_q & oe_f_q) : oe_r_q;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      ddio_out_cell #(
         .INVERT (INV_EN),
         .INIT   (INIT_HI)
      ) u_cell (
         .outclock (outclock),
         .aclr_n   (aclr_n),
         .ena      (outclocken),
         .sclr     (sclr),
         .sset     (sset),
         .d_h      (datain_h[i]),
         .d_l      (datain_l[i]),
         .q        (drv[i])
      );
   end

   assign dataout = oe_eff ? drv : {WIDTH{1'bz}};

endmodule

// File: tb/tb_altddio_out.sv
// Bench for altddio_out: a plain-default instance and an inverted, registered/extended-oe,
// power-up-high instance share stimulus and are checked against a per-rise word model.
module tb_altddio_out;

   logic       outclock = 1'b0;
   logic       aclr_n;
   logic [3:0] datain_h, datain_l;
   logic       outclocken, oe_in, sclr, sset;
   wire  [3:0] dout_a, dout_b;

   altddio_out #(
      .WIDTH (4)
   ) u_a (
      .outclock (outclock), .aclr_n (aclr_n), .datain_h (datain_h), .datain_l (datain_l),
      .outclocken (outclocken), .oe (oe_in), .sclr (sclr), .sset (sset), .dataout (dout_a)
   );

   altddio_out #(
      .WIDTH             (4),
      .INVERT_OUTPUT     ("ON"),
      .OE_REG            ("REGISTERED"),
      .EXTEND_OE_DISABLE ("ON"),
      .POWER_UP_HIGH     ("ON")
   ) u_b (
      .outclock (outclock), .aclr_n (aclr_n), .datain_h (datain_h), .datain_l (datain_l),
      .outclocken (outclocken), .oe (oe_in), .sclr (sclr), .sset (sset), .dataout (dout_b)
   );

   always #5 outclock = ~outclock;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   // Model: the word (h,l) captured at the most recent enabled rise, plus the registered oe
   // now and as it stood before the latest rise.
   logic [3:0] ha, la, hb, lb;
   bit         oer, oer_prev;

   function automatic logic [3:0] drive(input bit en, input logic [3:0] v);
      return en ? v : 4'bzzzz;
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      ha = 4'h0; la = 4'h0;
      hb = 4'hF; lb = 4'hF;
      oer = 1'b0; oer_prev = 1'b0;
   endtask

   task automatic model_rise();
      oer_prev = oer;
      if (outclocken) begin
         oer = oe_in;
         ha = datain_h; la = datain_l;
         hb = datain_h; lb = datain_l;
`ifdef ALTDDIO_OUT_SYNC_CTRL_EN
         if (sclr) begin
            ha = 4'h0; la = 4'h0; hb = 4'h0; lb = 4'h0;
         end else if (sset) begin
            ha = 4'hF; la = 4'hF; hb = 4'hF; lb = 4'hF;
         end
`endif
      end
   endtask

   task automatic chk_high(input string tag);
      chk({tag, "_a_hi"}, dout_a, drive(oe_in, ha));
      chk({tag, "_b_hi"}, dout_b, drive(oer && oer_prev, ~hb));
   endtask

   task automatic chk_low(input string tag);
      chk({tag, "_a_lo"}, dout_a, drive(oe_in, la));
      chk({tag, "_b_lo"}, dout_b, drive(oer, ~lb));
   endtask

   task automatic step(input string tag, input logic [3:0] h, input logic [3:0] l,
                       input logic o, input logic en, input logic sc, input logic ss);
      datain_h = h; datain_l = l; oe_in = o; outclocken = en; sclr = sc; sset = ss;
      @(posedge outclock);
      model_rise();
      #2;
      chk_high(tag);
      @(negedge outclock);
      #2;
      chk_low(tag);
   endtask

   initial begin
      aclr_n = 1'b0;
      datain_h = 4'h0; datain_l = 4'h0;
      outclocken = 1'b1; oe_in = 1'b1; sclr = 1'b0; sset = 1'b0;
      model_reset();
      #2;
      chk_low("reset");
      #1 aclr_n = 1'b1;

      step("clkfwd0", 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
      step("clkfwd1", 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
      step("pat_a5", 4'hA, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
      step("pat_a5b", 4'hA, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
      step("hold0", 4'h3, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
      step("hold1", 4'h3, 4'hC, 1'b1, 1'b0, 1'b0, 1'b0);
      step("oe_off", 4'h3, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0);
      step("oe_off2", 4'h7, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0);
      step("oe_on", 4'h6, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0);
      step("oe_on2", 4'h1, 4'hE, 1'b1, 1'b1, 1'b0, 1'b0);

      // Asynchronous clear in the middle of a high phase.
      datain_h = 4'hB; datain_l = 4'h4;
      @(posedge outclock);
      model_rise();
      #2 aclr_n = 1'b0;
      #1;
      model_reset();
      chk_high("aclr");
      @(negedge outclock);
      #2;
      chk_low("aclr");
      aclr_n = 1'b1;
      step("post_aclr", 4'h2, 4'hD, 1'b1, 1'b1, 1'b0, 1'b0);
      step("post_aclr2", 4'h2, 4'hD, 1'b1, 1'b1, 1'b0, 1'b0);

`ifdef ALTDDIO_OUT_SYNC_CTRL_EN
      step("sclr", 4'h5, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0);
      step("sset", 4'h5, 4'hA, 1'b1, 1'b1, 1'b0, 1'b1);
      step("sclr_sset", 4'h5, 4'hA, 1'b1, 1'b1, 1'b1, 1'b1);
      step("sclr_noen", 4'h9, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0);
`endif

      for (int i = 0; i < 40; i++) begin
         step("rand", 4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 4) != 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
